rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: single-cycle source A vs buffered long-latency
// source B, with anti-starvation and a one-bit-per-register pending-write scoreboard.

package rf_wb_pkg;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  output logic [NREGS-1:0]  busy,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wd
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic [NREGS-1:0]   busy_q, busy_d;
  logic               rf_we_d;
  wb_entry_t          win_entry;
  wb_entry_t          head;
  logic               fifo_empty;
  logic               a_win;
  logic               b_win;
  logic               push;
  logic               pop;
  logic [NREGS-1:0]   set_vec;
  logic [NREGS-1:0]   clr_vec;

  // Handshakes depend only on registered state, never on the valids.
  always_comb begin
    a_ready = (starve_q != STV_W'(STARVE_MAX));
    b_ready = (count_q < CNT_W'(DEPTH));
  end

  // Winner selection: A first unless B has been starved for STARVE_MAX cycles.
  always_comb begin
    fifo_empty = (count_q == '0);
    head       = mem[rd_ptr_q];
    a_win      = a_valid && a_ready;
    b_win      = !a_win && !fifo_empty;
    push       = b_valid && b_ready;
    pop        = b_win;
    win_entry  = head;
    if (a_win) begin
      win_entry.addr = a_addr;
      win_entry.data = a_data;
    end
    // x0 writes still handshake and pop, but never reach the register file.
    rf_we_d = (a_win || b_win) && (win_entry.addr != '0);
  end

  // FIFO bookkeeping; b_ready guarantees no push when full, b_win no pop when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || b_win) begin
      starve_d = '0;
    end else if (a_win) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // Scoreboard: clear on B retirement, set on issue; set wins on collision.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && (issue_rd != '0)) set_vec = NREGS'(1) << issue_rd;
    if (b_win)                           clr_vec = NREGS'(1) << head.addr;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  // Storage array carries no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q].addr <= b_addr;
      mem[wr_ptr_q].data <= b_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      busy_q   <= '0;
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wd    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
      rf_we    <= rf_we_d;
      if (a_win || b_win) begin
        rf_addr <= win_entry.addr;
        rf_wd   <= win_entry.data;
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, A/B paths, FIFO streaming,
// starvation, x0 and scoreboard corner cases, asynchronous mid-run reset.

module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;

  int n_checks = 0;
  int n_pass   = 0;

  rf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .busy       (busy),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wd      (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid     = 1'b0;
    a_addr      = '0;
    a_data      = '0;
    b_valid     = 1'b0;
    b_addr      = '0;
    b_data      = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic push_b(input logic [4:0] addr, input logic [31:0] data);
    b_valid = 1'b1;
    b_addr  = addr;
    b_data  = data;
  endtask

  task automatic drive_a(input logic [4:0] addr, input logic [31:0] data);
    a_valid = 1'b1;
    a_addr  = addr;
    a_data  = data;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_we",   32'(rf_we),   32'd0);
    check("rst_rf_addr", 32'(rf_addr), 32'd0);
    check("rst_rf_wd",   rf_wd,        32'd0);
    check("rst_busy",    busy,         32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    rst_n = 1'b1;

    // A alone
    drive_a(5'd5, 32'h11);
    check("a_alone_ready", 32'(a_ready), 32'd1);
    step();
    idle();
    check("a_alone_we",   32'(rf_we),   32'd1);
    check("a_alone_addr", 32'(rf_addr), 32'd5);
    check("a_alone_wd",   rf_wd,        32'h11);
    step();
    check("a_alone_we_off", 32'(rf_we), 32'd0);

    // B alone with scoreboard
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    step();
    idle();
    check("b_alone_busy_set", busy, 32'h0000_0080);
    push_b(5'd7, 32'hAB);
    check("b_alone_b_ready", 32'(b_ready), 32'd1);
    step();
    idle();
    check("b_alone_c2_we",   32'(rf_we), 32'd0);
    check("b_alone_c2_busy", busy,       32'h0000_0080);
    step();
    check("b_alone_c3_we",   32'(rf_we),   32'd1);
    check("b_alone_c3_addr", 32'(rf_addr), 32'd7);
    check("b_alone_c3_wd",   rf_wd,        32'hAB);
    check("b_alone_c3_busy", busy,         32'd0);
    step();
    check("b_alone_c4_we", 32'(rf_we), 32'd0);

    // Streaming B: push and pop overlap, b_ready never drops
    for (int i = 0; i < 3; i++) begin
      push_b(5'(i + 1), 32'h100 + 32'(i + 1));
      check($sformatf("stream_b_ready_%0d", i), 32'(b_ready), 32'd1);
      step();
      if (i > 0) begin
        check($sformatf("stream_wd_%0d", i - 1), rf_wd, 32'h100 + 32'(i));
        check($sformatf("stream_we_%0d", i - 1), 32'(rf_we), 32'd1);
      end
    end
    idle();
    step();
    check("stream_wd_2",   rf_wd,        32'h103);
    check("stream_addr_2", 32'(rf_addr), 32'd3);
    step();
    check("stream_we_off", 32'(rf_we), 32'd0);

    // Starvation: one B entry behind a continuous A stream
    drive_a(5'd10, 32'hA0);
    push_b(5'd4, 32'hB4);
    step();
    b_valid = 1'b0;
    check("starve_wd_a0", rf_wd, 32'hA0);
    for (int i = 1; i <= 4; i++) begin
      a_data = 32'hA0 + 32'(i);
      check($sformatf("starve_a_ready_%0d", i), 32'(a_ready), 32'd1);
      step();
      check($sformatf("starve_wd_a%0d", i), rf_wd, 32'hA0 + 32'(i));
    end
    a_data = 32'hA5;
    check("starve_a_ready_blocked", 32'(a_ready), 32'd0);
    step();
    check("starve_b_addr", 32'(rf_addr), 32'd4);
    check("starve_b_wd",   rf_wd,        32'hB4);
    a_data = 32'hA6;
    check("starve_a_ready_back", 32'(a_ready), 32'd1);
    step();
    check("starve_resume_wd",   rf_wd,        32'hA6);
    check("starve_resume_addr", 32'(rf_addr), 32'd10);
    idle();
    step();

    // x0 writes are consumed silently
    push_b(5'd0, 32'hDEAD);
    step();
    idle();
    step();
    check("b_x0_we",      32'(rf_we),   32'd0);
    check("b_x0_b_ready", 32'(b_ready), 32'd1);
    drive_a(5'd0, 32'hBEEF);
    step();
    idle();
    check("a_x0_we", 32'(rf_we), 32'd0);

    // Scoreboard: issue x0 ignored, set beats clear, A never touches busy
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    step();
    issue_rd = 5'd0;
    step();
    idle();
    check("busy_x9_set_x0_ignored", busy, 32'h0000_0200);
    drive_a(5'd9, 32'h55);
    step();
    idle();
    check("busy_a_write_no_clear", busy, 32'h0000_0200);
    push_b(5'd9, 32'h99);
    step();
    idle();
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    step();
    idle();
    check("collide_we",   32'(rf_we),   32'd1);
    check("collide_wd",   rf_wd,        32'h99);
    check("collide_busy", busy,         32'h0000_0200);
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    step();
    idle();
    check("reissue_busy", busy, 32'h0000_0200);

    // Fill the FIFO behind A traffic, then reset asynchronously mid-cycle
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    drive_a(5'd1, 32'h1);
    push_b(5'd12, 32'hC0);
    step();
    issue_valid = 1'b0;
    push_b(5'd13, 32'hC1);
    step();
    b_valid = 1'b0;
    check("full_b_ready", 32'(b_ready), 32'd0);
    check("full_busy",    busy,         32'h0000_1200);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_we",      32'(rf_we),   32'd0);
    check("async_rst_busy",    busy,         32'd0);
    check("async_rst_b_ready", 32'(b_ready), 32'd1);
    check("async_rst_a_ready", 32'(a_ready), 32'd1);
    idle();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst_no_stale_%0d", i), 32'(rf_we), 32'd0);
    end
    drive_a(5'd3, 32'h33);
    step();
    idle();
    check("post_rst_a_we", 32'(rf_we), 32'd1);
    check("post_rst_a_wd", rf_wd,      32'h33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
